// File: rtl/crc_pkg.sv
// Shared definitions for the CRC transmit path: widths, generator polynomial,
// arbiter FSM encoding and the bit-serial CRC remainder function.
package crc_pkg;

    localparam int BW     = 4;
    localparam int CRC_BW = 3;
    localparam int CW     = BW + CRC_BW;
    localparam logic [CRC_BW-1:0] POLY = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // Remainder of (data << CRC_BW) mod {1, POLY}, shifting data in MSB first.
    function automatic logic [CRC_BW-1:0] crc_calc(input logic [BW-1:0] data);
        logic [CRC_BW-1:0] crc;
        logic              fb;
        crc = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            fb  = data[i] ^ crc[CRC_BW-1];
            crc = {crc[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc_tx_arbiter_if.sv
// Bundle of the two source streams and the codeword output stream.
// Valid/ready: a word moves on a rising edge where valid and ready are both high;
// valid, data and last stay stable until that edge, ready may depend on valid.
interface crc_tx_arbiter_if;
    import crc_pkg::*;

    logic [BW-1:0] s0_data;
    logic          s0_valid;
    logic          s0_last;
    logic          s0_ready;
    logic [BW-1:0] s1_data;
    logic          s1_valid;
    logic          s1_last;
    logic          s1_ready;
    logic [CW-1:0] m_data;
    logic          m_valid;
    logic          m_src;
    logic          m_last;
    logic          m_ready;
    logic          busy;

    // master: the arbiter side; slave: the sources and the downstream sink.
    modport master (
        input  s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, m_ready,
        output s0_ready, s1_ready, m_data, m_valid, m_src, m_last, busy
    );
    modport slave (
        output s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, m_ready,
        input  s0_ready, s1_ready, m_data, m_valid, m_src, m_last, busy
    );

endinterface

// File: rtl/crc_encoder.sv
// Combinational systematic CRC encoder: codeword is {data, crc(data)}.
module crc_encoder
    import crc_pkg::*;
(
    input  logic [BW-1:0] i_data,
    output logic [CW-1:0] o_cw
);

    assign o_cw = {i_data, crc_calc(i_data)};

endmodule

// File: rtl/crc_tx_arbiter.sv
// Two-source packet round-robin arbiter in front of one shared CRC encoder,
// with a single registered codeword output stage.
module crc_tx_arbiter
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    crc_tx_arbiter_if.master bus,
    output state_t           o_state,
    output logic             o_rr_ptr
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr_ptr;
    logic          w_rr_nxt;

    logic          w_load_ok;
    logic          w_any;
    logic          w_gnt;
    logic          w_accept;
    logic [BW-1:0] w_data;
    logic          w_last;
    logic [CW-1:0] w_cw;

    logic [CW-1:0] r_m_data;
    logic          r_m_valid;
    logic          r_m_src;
    logic          r_m_last;

    assign w_load_ok = !r_m_valid || bus.m_ready;

    // rr_ptr holds the last winner; it starts at 1 so source 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_rr_ptr <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        if (w_accept) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_rr_nxt    = w_gnt;
            end else begin
                w_state_nxt = w_gnt ? LOCK1 : LOCK0;
            end
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_gnt = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.s0_valid) begin
                    w_any = 1'b1;
                    w_gnt = bus.s1_valid ? ~r_rr_ptr : 1'b0;
                end else if (bus.s1_valid) begin
                    w_any = 1'b1;
                    w_gnt = 1'b1;
                end
            end
            LOCK0: begin
                w_any = bus.s0_valid;
                w_gnt = 1'b0;
            end
            LOCK1: begin
                w_any = bus.s1_valid;
                w_gnt = 1'b1;
            end
            default: begin
                w_any = 1'b0;
                w_gnt = 1'b0;
            end
        endcase
        w_accept = w_load_ok && w_any;
    end

    assign w_data = w_gnt ? bus.s1_data : bus.s0_data;
    assign w_last = w_gnt ? bus.s1_last : bus.s0_last;

    crc_encoder u_enc (
        .i_data (w_data),
        .o_cw   (w_cw)
    );

    // A stalled codeword keeps its register; an empty accept slot drops m_valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_src   <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_load_ok) begin
            r_m_valid <= w_accept;
            if (w_accept) begin
                r_m_data <= w_cw;
                r_m_src  <= w_gnt;
                r_m_last <= w_last;
            end
        end
    end

    assign bus.s0_ready = w_accept && !w_gnt;
    assign bus.s1_ready = w_accept &&  w_gnt;
    assign bus.m_data   = r_m_data;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_src    = r_m_src;
    assign bus.m_last   = r_m_last;
    assign bus.busy     = (r_state != IDLE) || r_m_valid;

    assign o_state  = r_state;
    assign o_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_crc_tx_arbiter.sv
// Self-checking bench for crc_tx_arbiter: directed arbitration, lock, stall and
// reset scenarios plus a data sweep, with a codeword scoreboard.
module tb_crc_tx_arbiter;
    import crc_pkg::*;

    logic   clk;
    logic   rstn;
    state_t dbg_state;
    logic   dbg_rr;

    int n_cmp;
    int n_err;
    int cyc;
    bit lat_chk;
    bit rnd_en;

    logic [8:0] exp_q[$];
    int         cyc_q[$];

    crc_tx_arbiter_if bus ();

    crc_tx_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.master),
        .o_state  (dbg_state),
        .o_rr_ptr (dbg_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference codeword by long division of the 7-bit dividend.
    function automatic logic [6:0] model_cw(input logic [3:0] d);
        logic [6:0] v;
        v = {d, 3'b000};
        for (int b = 6; b >= 3; b--) begin
            if (v[b]) v = v ^ (7'b1011 << (b - 3));
        end
        return {d, v[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: pop on each output handshake, push on each source handshake.
    always @(negedge clk) begin
        logic [8:0] e;
        int         c;
        if (!rstn) begin
            exp_q.delete();
            cyc_q.delete();
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {bus.m_src, bus.m_last, bus.m_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    chk("out_word", {bus.m_src, bus.m_last, bus.m_data}, e);
                    if (lat_chk) chk("latency", cyc - c, 1);
                end
            end
            if (bus.s0_valid && bus.s0_ready) begin
                exp_q.push_back({1'b0, bus.s0_last, model_cw(bus.s0_data)});
                cyc_q.push_back(cyc);
            end
            if (bus.s1_valid && bus.s1_ready) begin
                exp_q.push_back({1'b1, bus.s1_last, model_cw(bus.s1_data)});
                cyc_q.push_back(cyc);
            end
            if (bus.s0_ready && bus.s1_ready) chk("one_ready", 1, 0);
        end
    end

    task automatic drive_word(input logic src, input logic [3:0] d, input logic last);
        int n;
        if (src == 1'b0) begin
            bus.s0_data = d; bus.s0_last = last; bus.s0_valid = 1'b1;
        end else begin
            bus.s1_data = d; bus.s1_last = last; bus.s1_valid = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(src ? bus.s1_ready : bus.s0_ready) && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("hs_timeout", (n < 40), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] lw[3];
        logic [3:0] sw[3];
        int         n;
        lw = '{4'h3, 4'hC, 4'h7};
        sw = '{4'h1, 4'h8, 4'hF};
        n_cmp = 0; n_err = 0; cyc = 0; lat_chk = 0; rnd_en = 0;
        rstn = 1'b0;
        bus.s0_data = '0; bus.s0_valid = 0; bus.s0_last = 0;
        bus.s1_data = '0; bus.s1_valid = 0; bus.s1_last = 0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_src", bus.m_src, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_rr", dbg_rr, 1);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk); #1;

        // Tie from reset: single-word packets from both, src 0 first then alternate.
        rstn = 1'b1;
        bus.s0_data = 4'h2; bus.s0_last = 1; bus.s0_valid = 1;
        bus.s1_data = 4'h0; bus.s1_last = 1; bus.s1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tie_s0_ready", bus.s0_ready, (k % 2 == 0));
            chk("tie_s1_ready", bus.s1_ready, (k % 2 == 1));
            chk("tie_state", dbg_state, IDLE);
            @(posedge clk); #1;
        end
        bus.s0_valid = 0; bus.s1_valid = 0;

        // Packet lock: s1 waits through s0's three-word packet.
        bus.s1_data = 4'h5; bus.s1_last = 1; bus.s1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            bus.s0_data = lw[k]; bus.s0_last = (k == 2); bus.s0_valid = 1;
            @(negedge clk);
            chk("lock_s0_ready", bus.s0_ready, 1);
            chk("lock_s1_ready", bus.s1_ready, 0);
            @(posedge clk); #1;
        end
        bus.s0_valid = 0;
        @(negedge clk);
        chk("lock_s1_next", bus.s1_ready, 1);
        @(posedge clk); #1;
        bus.s1_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single source, back to back, one-cycle latency.
        lat_chk = 1;
        for (int k = 0; k < 3; k++) drive_word(1'b0, sw[k], (k == 2));
        bus.s0_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        lat_chk = 0;

        // Backpressure: hold 0x45 for four cycles with s1 pending.
        drive_word(1'b0, 4'h8, 1'b1);
        bus.s0_valid = 0;
        bus.m_ready = 0;
        bus.s1_data = 4'h3; bus.s1_last = 1; bus.s1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_m_data", bus.m_data, 7'h45);
            chk("bp_m_valid", bus.m_valid, 1);
            chk("bp_readys", {bus.s0_ready, bus.s1_ready}, 0);
        end
        @(posedge clk); #1;
        bus.m_ready = 1;
        @(negedge clk);
        chk("bp_release", bus.s1_ready, 1);
        @(posedge clk); #1;
        bus.s1_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an s1 packet while a codeword is held.
        drive_word(1'b1, 4'h6, 1'b0);
        chk("mid_locked", dbg_state, LOCK1);
        bus.s1_data = 4'h9; bus.s1_last = 0;
        bus.m_ready = 0;
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        bus.s1_valid = 0;
        bus.m_ready = 1;
        @(negedge clk);
        chk("mid_m_valid", bus.m_valid, 0);
        chk("mid_state", dbg_state, IDLE);
        chk("mid_busy", bus.busy, 0);
        @(posedge clk); #1;
        bus.s0_data = 4'hA; bus.s0_last = 1; bus.s0_valid = 1;
        bus.s1_data = 4'hB; bus.s1_last = 1; bus.s1_valid = 1;
        @(negedge clk);
        chk("mid_tie_s0", bus.s0_ready, 1);
        chk("mid_tie_s1", bus.s1_ready, 0);
        @(posedge clk); #1;
        bus.s0_valid = 0;
        @(negedge clk);
        chk("mid_tie_s1_next", bus.s1_ready, 1);
        @(posedge clk); #1;
        bus.s1_valid = 0;

        // Sweep all data values through s1 under random downstream readiness.
        rnd_en = 1;
        fork
            begin
                while (rnd_en) begin
                    @(posedge clk); #1;
                    bus.m_ready = 1'($urandom_range(0, 1));
                end
                bus.m_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 16; i++) drive_word(1'b1, 4'(i), 1'b1);
        bus.s1_valid = 0;
        rnd_en = 0;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q", exp_q.size(), 0);
        chk("drain_valid", bus.m_valid, 0);
        chk("end_state", dbg_state, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc_tx_arbiter.md
Name: crc_tx_arbiter

Overview:
- Shares one systematic CRC encoder (BW data bits -> BW+CRC_BW codeword bits) between two packet sources.
- Round-robin arbitration at packet granularity: once a source wins, it keeps the encoder until its last word is accepted.
- Output is a registered codeword stream with valid/ready, source tag and last flag, and feeds the serializer/channel stage.
- Encoding latency matches the existing transmitter: one clock from input accept to codeword valid.

Parameters:
- BW, 4, data word width.
- CRC_BW, 3, CRC width; codeword width is BW+CRC_BW.
- POLY, 3'b011, generator polynomial without its implicit MSB (default x^3+x+1).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- s0_data  in  BW  source 0 data word.
- s0_valid  in  1  source 0 word valid.
- s0_last  in  1  source 0 final word of packet.
- s0_ready  out  1  source 0 word accepted this cycle when high together with s0_valid.
- s1_data  in  BW  source 1 data word.
- s1_valid  in  1  source 1 word valid.
- s1_last  in  1  source 1 final word of packet.
- s1_ready  out  1  source 1 word accepted this cycle when high together with s1_valid.
- m_data  out  BW+CRC_BW  codeword {data, crc}; data occupies the MSBs.
- m_valid  out  1  codeword valid.
- m_src  out  1  source index of m_data.
- m_last  out  1  codeword is the last of its packet.
- m_ready  in  1  downstream accept.
- busy  out  1  high in LOCK0 or LOCK1, or while m_valid is high.

Behaviour:
- Reset (rstn=0 at a clk edge): m_valid=0, m_data=0, m_src=0, m_last=0, state=IDLE, rr_ptr=1 (so source 0 wins the first tie). Reset mid-packet drops the packet and any held codeword; no partial output follows.
- Output register can load: load_ok = !m_valid || m_ready. This gives full throughput of one word per cycle with no bubble.
- sX_ready is combinational. It is high only when load_ok=1 and source X is granted this cycle. At most one ready is high in any cycle.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE grant:
  - If only one source is valid, that source is granted.
  - If both are valid, the source != rr_ptr is granted.
  - The first word is accepted in the same cycle.
  - If that word has last=1: stay in IDLE and set rr_ptr=X.
  - Otherwise: go to LOCKX.
- LOCKX: only source X may be granted; the other source's ready is held low. On accept with sX_last=1: go to IDLE and set rr_ptr=X.
- A single-word packet (last on its first word) never leaves IDLE. It still updates rr_ptr.
- Accept cycle N: at edge N+1, m_data={data, crc(data)}, m_src=X, m_last=sX_last, m_valid=1.
- If m_ready=0 while m_valid=1: the output holds stable and both readys stay low. The FSM and rr_ptr do not change.
- No accept while m_valid && m_ready: m_valid clears at the next edge.
- CRC: remainder of (data << CRC_BW) mod {1, POLY}, computed by the combinational encoder. All arithmetic is modulo 2.
- Valid asserted without a grant is not an error; the source simply waits. A source must hold its data stable until accepted.

Decomposition:
- Shared package crc_pkg:
  - localparams BW, CRC_BW, CW = BW+CRC_BW, POLY;
  - FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2);
  - function crc_calc(data) returning CRC_BW bits.
- One sub-module, crc_encoder: combinational data -> {data, crc}. It is instantiated once, after the grant mux, and is reusable by the existing transmitter.

Test Plan:
- Single source: s0 sends 0x1, 0x8, 0xF with last on 0xF, m_ready=1 -> m_data 0x0B, 0x45, 0x7F on three consecutive cycles, each one cycle after accept; m_src=0; m_last only on 0x7F.
- Tie arbitration: both sources valid from reset with single-word packets, s0 data=0x2 and s1 data=0x0 -> outputs alternate 0x16 (src 0) and 0x00 (src 1), starting with src 0.
- Packet lock: s0 sends a 3-word packet while s1 is valid throughout -> s1_ready stays low until s0's last word is accepted; s1's first word is accepted in the next cycle.
- Backpressure: m_ready=0 for 4 cycles while holding 0x45 -> m_data stays 0x45, both readys stay low, and there are no duplicate or lost words after release.
- Reset mid-packet: rstn=0 for one cycle during an s1 packet with m_valid=1 -> next cycle m_valid=0, state=IDLE, and source 0 wins the following tie.
- Zero/all-ones sweep: all 16 data values through s1 -> every codeword matches crc_calc, and the bench counts zero errors.
